// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// fast paths for divide-by-zero and signed overflow, start/busy/valid handshake with flush.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic                 fast_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     opb_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     result_q;
    logic                 valid_q;

    logic                 accept;
    logic                 is_div;
    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 neg_start;
    logic                 div_zero, ovf, fast;
    logic [WIDTH-1:0]     fast_val;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_bit;
    logic [WIDTH-1:0]     rem_next, quo_next;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     mul_res, div_raw, div_res, final_res;

    // Operand decode and fast-path detection, evaluated on the accepting edge.
    always_comb begin
        accept    = start && !flush && (state_q == StIdle || state_q == StDone);
        is_div    = funct3[2];
        a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg     = a_signed && SrcA[WIDTH-1];
        b_neg     = b_signed && SrcB[WIDTH-1];
        a_mag     = a_neg ? (-SrcA) : SrcA;
        b_mag     = b_neg ? (-SrcB) : SrcB;
        // Remainder follows the dividend; everything else is the product of signs.
        neg_start = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div && (SrcB == '0);
        ovf       = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
        fast      = div_zero || ovf;
        if (div_zero) begin
            fast_val = funct3[1] ? SrcA : '1;
        end else begin
            fast_val = funct3[1] ? '0 : SrcA;
        end
    end

    // One iteration step for each datapath.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        div_shift = {rem_q, prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_bit   = !div_diff[WIDTH];
        rem_next  = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {prod_q[WIDTH-2:0], div_bit};
    end

    // Sign fix and result selection, consumed in DONE.
    always_comb begin
        prod_fix  = neg_q ? (-prod_q) : prod_q;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        div_raw   = op_q[1] ? rem_q : prod_q[WIDTH-1:0];
        div_res   = neg_q ? (-div_raw) : div_raw;
        if (fast_q) begin
            final_res = prod_q[WIDTH-1:0];
        end else begin
            final_res = op_q[2] ? div_res : mul_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = fast ? StDone : StCalc;
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (accept) begin
                    state_d = fast ? StDone : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q == StCalc);
        result_valid = valid_q;
        Result       = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            fast_q <= 1'b0;
            prod_q <= '0;
            opb_q  <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            op_q   <= funct3;
            neg_q  <= neg_start;
            fast_q <= fast;
            cnt_q  <= '0;
            rem_q  <= '0;
            // Multiplier (or dividend) sits in the low half and shifts out as we iterate.
            opb_q  <= is_div ? b_mag : a_mag;
            if (fast) begin
                prod_q <= {{WIDTH{1'b0}}, fast_val};
            end else begin
                prod_q <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            end
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q[2]) begin
                prod_q <= {prod_q[2*WIDTH-1:WIDTH], quo_next};
                rem_q  <= rem_next;
            end else begin
                prod_q <= mul_next;
            end
        end
    end

    // DONE is the sign-fix stage; a flush arriving in DONE does not cancel it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= (state_q == StDone);
            if (state_q == StDone) result_q <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy;
    logic        result_valid;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .Result       (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one op; k counts edges after the accepting edge, sampled 1ns after each.
    // flush_at/inject_at < 0 disable the flush or mid-CALC start injection.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int exp_busy, input int flush_at, input int inject_at);
        int          lat;
        int          nbusy;
        int          pulses;
        logic [31:0] res;
        lat = -1; nbusy = 0; pulses = 0; res = '0;
        @(negedge clk);
        start = 1'b1; funct3 = f; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = ~f; SrcA = ~a; SrcB = ~b;
        for (int k = 0; k < 45; k++) begin
            if (busy) nbusy++;
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = Result;
                end
            end
            flush = (k == flush_at);
            if (k == inject_at) begin
                start = 1'b1; funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        if (flush_at >= 0) begin
            check({tag, "/pulses"}, pulses, 0);
            check({tag, "/held"}, Result, exp);
            check({tag, "/busy_after"}, {31'b0, busy}, 0);
        end else begin
            check({tag, "/res"}, res, exp);
            check({tag, "/lat"}, lat, exp_lat);
            check({tag, "/pulses"}, pulses, 1);
        end
        check({tag, "/busy_cyc"}, nbusy, exp_busy);
    endtask

    int          k1, k2;
    logic [31:0] r1, r2;

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
        #12;
        check("rst/busy", {31'b0, busy}, 0);
        check("rst/valid", {31'b0, result_valid}, 0);
        check("rst/result", Result, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mul_7x-3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 32, -1, -1);
        run_op("mul_shift",   3'b000, 32'h12345678, 32'h10,       32'h23456780, 33, 32, -1, -1);
        run_op("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32, -1, -1);
        run_op("mulhu_half",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32, -1, -1);
        run_op("mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32, -1, -1);
        run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, -1, -1);
        run_op("div_-7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 32, -1, -1);
        run_op("rem_-7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 32, -1, -1);
        run_op("div_20_-3",   3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, 32, -1, -1);
        run_op("rem_20_-3",   3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        33, 32, -1, -1);
        run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33, 32, -1, -1);
        run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33, 32, -1, -1);

        // Flush after 10 busy cycles: no pulse, previous result (2) retained.
        run_op("flush",       3'b100, 32'd20,       32'hFFFFFFFD, 32'd2,        0,  10,  9, -1);

        run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, -1, -1);
        run_op("rem_by0",     3'b110, 32'h1234,     32'd0,        32'h1234,     1,  0, -1, -1);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, -1, -1);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, -1, -1);

        // A start during CALC with other operands must be ignored.
        run_op("ignore_start", 3'b000, 32'd7,       32'hFFFFFFFD, 32'hFFFFFFEB, 33, 32, -1, 5);

        // Back-to-back: start held high across DONE; second op switches operands in CALC.
        k1 = -1; k2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'hFFFFFFFD;
        @(posedge clk); #1;
        funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
        for (int k = 0; k < 80; k++) begin
            if (result_valid) begin
                if (k1 < 0) begin
                    k1 = k; r1 = Result; start = 1'b0;
                end else if (k2 < 0) begin
                    k2 = k; r2 = Result;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("b2b/res1", r1, 32'hFFFFFFEB);
        check("b2b/lat1", k1, 33);
        check("b2b/res2", r2, 32'd14);
        check("b2b/gap", k2 - k1, 33);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("mid_rst/pre_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst/busy", {31'b0, busy}, 0);
        check("mid_rst/valid", {31'b0, result_valid}, 0);
        check("mid_rst/result", Result, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op("after_rst",   3'b000, 32'd3,        32'd5,        32'd15,       33, 32, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
